// File: rtl/jam_pkg.sv
// Shared types and helpers for the job-assignment DP engine.
// Holds the FSM state encoding plus the constant and arithmetic helpers used
// by jam_dp_engine and jam_dp_table. No ports; import with jam_pkg::*.
package jam_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, CAL, DONE} state_t;

  // Ceiling log2 for sizing; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Number of set bits in a job mask (masks are at most 8 bits wide).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  // Unsigned add clamped at 2^w - 1; operands are already below the clamp.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int w);
    logic [31:0] lim;
    lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (a > lim - b) ? lim : a + b;
  endfunction

endpackage

// File: rtl/jam_dp_table.sv
// Subset-DP storage: one (best cost, optimal count) pair per job mask.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   clr                 one-cycle parallel clear to the start-of-run values
//   addr_a/dp_a/cnt_a   combinational read of the current mask
//   addr_b/dp_b/cnt_b   combinational read of the successor mask
//   we/wr_addr/wr_dp/wr_cnt  single write port
// Cleared state: dp[0]=0, cnt[0]=1; every other mask dp=all-ones (unreached), cnt=0.
module jam_dp_table #(
  parameter int N    = 8,
  parameter int MCW  = 11,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            clr,
  input  logic [N-1:0]    addr_a,
  output logic [MCW-1:0]  dp_a,
  output logic [CNTW-1:0] cnt_a,
  input  logic [N-1:0]    addr_b,
  output logic [MCW-1:0]  dp_b,
  output logic [CNTW-1:0] cnt_b,
  input  logic            we,
  input  logic [N-1:0]    wr_addr,
  input  logic [MCW-1:0]  wr_dp,
  input  logic [CNTW-1:0] wr_cnt
);

  localparam int M = 1 << N;

  logic [MCW-1:0]  dp_mem  [M];
  logic [CNTW-1:0] cnt_mem [M];

  assign dp_a  = dp_mem[addr_a];
  assign cnt_a = cnt_mem[addr_a];
  assign dp_b  = dp_mem[addr_b];
  assign cnt_b = cnt_mem[addr_b];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST || clr) begin
      for (int i = 0; i < M; i++) begin
        dp_mem[i]  <= (i == 0) ? '0 : '1;
        cnt_mem[i] <= (i == 0) ? CNTW'(1) : '0;
      end
    end else if (we) begin
      dp_mem[wr_addr]  <= wr_dp;
      cnt_mem[wr_addr] <= wr_cnt;
    end
  end

endmodule

// File: rtl/jam_dp_engine.sv
// Job-assignment solver: loads an N x N cost matrix from an external ROM,
// runs a subset DP over all job masks, and reports the minimum total cost and
// the (saturating) number of optimal assignments.
// Ports:
//   CLK, RST     clock, asynchronous active-high reset
//   Start        run request, only honoured in IDLE
//   Cost         ROM data for (W, J), captured at the clock edge
//   W, J         ROM address (worker, job); held during CAL
//   Busy         high in LOAD/CAL/DONE
//   Valid        one-cycle result strobe
//   MinCost      minimum total cost, held until the next Valid
//   MatchCount   number of optimal assignments, held until the next Valid
module jam_dp_engine
  import jam_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int CW   = 7,
  parameter  int CNTW = 16,
  localparam int IW   = imax(1, clog2(N)),
  localparam int MCW  = CW + clog2(N) + 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic [CW-1:0]   Cost,
  output logic [IW-1:0]   W,
  output logic [IW-1:0]   J,
  output logic            Busy,
  output logic            Valid,
  output logic [MCW-1:0]  MinCost,
  output logic [CNTW-1:0] MatchCount
);

  localparam int M = 1 << N;

  state_t          state;
  logic [N-1:0]    mask;
  logic [IW-1:0]   job;
  logic [CW-1:0]   cost_m [N][N];

  logic            clr;
  logic [N-1:0]    nm;
  logic [7:0]      mask8;
  logic [IW-1:0]   w_pop;
  logic [MCW-1:0]  dp_a, dp_b, nd, wr_dp;
  logic [CNTW-1:0] cnt_a, cnt_b, cnt_sat, wr_cnt;
  logic            step_ok, we;

  // The table is reset to its start-of-run contents on the same edge that
  // leaves IDLE, so back-to-back runs never see the previous run's values.
  assign clr = (state == IDLE) && Start;

  jam_dp_table #(.N(N), .MCW(MCW), .CNTW(CNTW)) u_table (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (clr),
    .addr_a  (mask),
    .dp_a    (dp_a),
    .cnt_a   (cnt_a),
    .addr_b  (nm),
    .dp_b    (dp_b),
    .cnt_b   (cnt_b),
    .we      (we),
    .wr_addr (nm),
    .wr_dp   (wr_dp),
    .wr_cnt  (wr_cnt)
  );

  // Worker for this step is the number of jobs already assigned in mask.
  assign mask8   = 8'(mask);
  assign w_pop   = IW'(popcount8(mask8));
  assign nm      = mask | (N'(1) << job);
  assign nd      = dp_a + MCW'(cost_m[w_pop][job]);
  assign cnt_sat = CNTW'(sat_add(32'(cnt_b), 32'(cnt_a), CNTW));
  assign step_ok = (state == CAL) && !mask[job] && (dp_a != '1);

  always_comb begin
    we     = 1'b0;
    wr_dp  = nd;
    wr_cnt = cnt_a;
    if (step_ok) begin
      if (nd < dp_b) begin
        we = 1'b1;
      end else if (nd == dp_b) begin
        we     = 1'b1;
        wr_dp  = dp_b;
        wr_cnt = cnt_sat;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (state == LOAD) cost_m[W][J] <= Cost;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      W          <= '0;
      J          <= '0;
      mask       <= '0;
      job        <= '0;
      Busy       <= 1'b0;
      Valid      <= 1'b0;
      MinCost    <= '0;
      MatchCount <= '0;
    end else begin
      Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state <= LOAD;
            Busy  <= 1'b1;
            W     <= '0;
            J     <= '0;
          end
        end
        LOAD: begin
          if (J == IW'(N - 1)) begin
            if (W == IW'(N - 1)) begin
              state <= CAL;
              mask  <= '0;
              job   <= '0;
            end else begin
              W <= W + 1'b1;
              J <= '0;
            end
          end else begin
            J <= J + 1'b1;
          end
        end
        CAL: begin
          if (job == IW'(N - 1)) begin
            job <= '0;
            if (mask == N'(M - 2)) begin
              // Point the read port at the full mask for the result.
              state <= DONE;
              mask  <= '1;
            end else begin
              mask <= mask + 1'b1;
            end
          end else begin
            job <= job + 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          Busy       <= 1'b0;
          Valid      <= 1'b1;
          MinCost    <= dp_a;
          MatchCount <= cnt_a;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_dp_engine.sv
// Directed bench for jam_dp_engine: N=8 (two count widths in lockstep),
// N=3 and N=2 instances, each fed from a bench-side cost ROM.
module tb_jam_dp_engine;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  int rom8 [8][8];
  int rom3 [3][3];
  int rom2 [2][2];

  // N=8, CNTW=16 and N=8, CNTW=8 share the Start strobe
  logic        start8;
  logic [6:0]  cost8, cost8s;
  logic [2:0]  w8, j8, w8s, j8s;
  logic        busy8, vld8, busy8s, vld8s;
  logic [10:0] min8, min8s;
  logic [15:0] mc8;
  logic [7:0]  mc8s;
  // N=3
  logic        start3, busy3, vld3;
  logic [6:0]  cost3;
  logic [1:0]  w3, j3;
  logic [9:0]  min3;
  logic [15:0] mc3;
  // N=2
  logic        start2, busy2, vld2;
  logic [6:0]  cost2;
  logic [0:0]  w2, j2;
  logic [8:0]  min2;
  logic [15:0] mc2;

  assign cost8  = 7'(rom8[w8][j8]);
  assign cost8s = 7'(rom8[w8s][j8s]);
  assign cost3  = 7'(rom3[w3][j3]);
  assign cost2  = 7'(rom2[w2][j2]);

  jam_dp_engine #(.N(8), .CW(7), .CNTW(16)) u8 (
    .CLK(CLK), .RST(RST), .Start(start8), .Cost(cost8), .W(w8), .J(j8),
    .Busy(busy8), .Valid(vld8), .MinCost(min8), .MatchCount(mc8));

  jam_dp_engine #(.N(8), .CW(7), .CNTW(8)) u8s (
    .CLK(CLK), .RST(RST), .Start(start8), .Cost(cost8s), .W(w8s), .J(j8s),
    .Busy(busy8s), .Valid(vld8s), .MinCost(min8s), .MatchCount(mc8s));

  jam_dp_engine #(.N(3), .CW(7), .CNTW(16)) u3 (
    .CLK(CLK), .RST(RST), .Start(start3), .Cost(cost3), .W(w3), .J(j3),
    .Busy(busy3), .Valid(vld3), .MinCost(min3), .MatchCount(mc3));

  jam_dp_engine #(.N(2), .CW(7), .CNTW(16)) u2 (
    .CLK(CLK), .RST(RST), .Start(start2), .Cost(cost2), .W(w2), .J(j2),
    .Busy(busy2), .Valid(vld2), .MinCost(min2), .MatchCount(mc2));

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill8(input int d, input int o);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++)
        rom8[w][j] = (w == j) ? d : o;
  endtask

  // Raise Start so it is sampled at the next edge (t0); leave it high if hold.
  task automatic kick(input int which, input bit hold);
    case (which)
      8:       start8 = 1'b1;
      3:       start3 = 1'b1;
      default: start2 = 1'b1;
    endcase
    @(posedge CLK); #1;
    if (!hold) begin
      start8 = 1'b0;
      start3 = 1'b0;
      start2 = 1'b0;
    end
  endtask

  // Counts edges until Valid; optionally pulses start8 mid-run at cycle poke.
  task automatic wait_vld(input int which, input int poke, output int cyc);
    logic v;
    cyc = 0;
    v   = 1'b0;
    while (!v && cyc < 3000) begin
      @(posedge CLK); #1;
      cyc++;
      if (poke > 0 && cyc == poke)     start8 = 1'b1;
      if (poke > 0 && cyc == poke + 1) start8 = 1'b0;
      case (which)
        8:       v = vld8;
        3:       v = vld3;
        default: v = vld2;
      endcase
    end
  endtask

  initial begin
    int cyc;
    RST    = 1'b1;
    start8 = 1'b0;
    start3 = 1'b0;
    start2 = 1'b0;
    fill8(0, 0);
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 3; j++)
        rom3[w][j] = (w + 1) * (j + 1);
    for (int w = 0; w < 2; w++)
      for (int j = 0; j < 2; j++)
        rom2[w][j] = 0;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", busy8, 0);
    chk("rst_valid", vld8, 0);
    chk("rst_min", min8, 0);
    chk("rst_mc", mc8, 0);
    chk("rst_w", w8, 0);
    chk("rst_j", j8, 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Identity-zero matrix; a Start pulse lands mid-run and must be ignored.
    fill8(0, 10);
    kick(8, 0);
    chk("a_busy", busy8, 1);
    wait_vld(8, 100, cyc);
    chk("a_latency", cyc, 2105);
    chk("a_min", min8, 0);
    chk("a_mc", mc8, 1);
    chk("a_mc_s", mc8s, 1);
    @(posedge CLK); #1;
    chk("a_valid_pulse", vld8, 0);
    chk("a_busy_end", busy8, 0);

    // All-5 with Start held: the run restarts as soon as IDLE is re-entered.
    fill8(5, 5);
    kick(8, 1);
    wait_vld(8, 0, cyc);
    chk("b_latency", cyc, 2105);
    chk("b_min", min8, 40);
    chk("b_mc", mc8, 40320);
    chk("b_min_s", min8s, 40);
    chk("b_mc_sat", mc8s, 255);
    fill8(7, 7);
    @(posedge CLK); #1;
    chk("c_restart_busy", busy8, 1);
    start8 = 1'b0;
    wait_vld(8, 0, cyc);
    chk("c_latency", cyc, 2105);
    chk("c_min", min8, 56);
    chk("c_mc", mc8, 40320);
    chk("c_mc_sat", mc8s, 255);

    // Reset during CAL, then a clean run.
    fill8(5, 5);
    kick(8, 0);
    repeat (500) @(posedge CLK);
    #1;
    chk("r_busy_cal", busy8, 1);
    RST = 1'b1;
    #1;
    chk("r_min", min8, 0);
    chk("r_mc", mc8, 0);
    chk("r_min_s", min8s, 0);
    chk("r_busy", busy8, 0);
    chk("r_w", w8, 0);
    chk("r_j", j8, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    fill8(3, 9);
    kick(8, 0);
    wait_vld(8, 0, cyc);
    chk("r2_latency", cyc, 2105);
    chk("r2_min", min8, 24);
    chk("r2_mc", mc8, 1);

    // N=3 product matrix: reversed pairing 3+4+3 is the unique optimum.
    kick(3, 0);
    wait_vld(3, 0, cyc);
    chk("n3_latency", cyc, 31);
    chk("n3_min", min3, 10);
    chk("n3_mc", mc3, 1);

    // N=2 all-zero: both permutations optimal; ROM walk is row-major.
    kick(2, 0);
    for (int i = 0; i < 4; i++) begin
      chk("n2_wj", {w2, j2}, i);
      if (i < 3) begin
        @(posedge CLK); #1;
      end
    end
    wait_vld(2, 0, cyc);
    chk("n2_latency", cyc + 3, 11);
    chk("n2_min", min2, 0);
    chk("n2_mc", mc2, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
